// File: rtl/mem_arb_pkg.sv
`default_nettype none
//============================================================================
// mem_arb_pkg : shared types, size codes and alignment helper for the
//               unified memory port arbiter.
// Revision    : 1.0
//============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_F = 2'd0,
        OWN_L = 2'd1,
        OWN_D = 2'd2
    } arb_owner_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Only the low three address bits matter for sizes up to a double word.
    function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
//============================================================================
// mem_arb_pick : combinational winner select; D has absolute priority,
//                F and L share by round-robin.
// Revision     : 1.0
//============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_f_req,
    input  logic       i_l_req,
    input  logic       i_d_req,
    input  logic       i_rr,
    output logic [2:0] o_grant,     // one-hot {D, L, F}
    output arb_owner_e o_owner
);

    always_comb begin
        o_grant = 3'b000;
        o_owner = OWN_F;
        if (i_d_req) begin
            o_grant = 3'b100;
            o_owner = OWN_D;
        end else if (i_f_req && i_l_req) begin
            if (i_rr) begin
                o_grant = 3'b010;
                o_owner = OWN_L;
            end else begin
                o_grant = 3'b001;
                o_owner = OWN_F;
            end
        end else if (i_l_req) begin
            o_grant = 3'b010;
            o_owner = OWN_L;
        end else if (i_f_req) begin
            o_grant = 3'b001;
            o_owner = OWN_F;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
//============================================================================
// mem_port_arbiter : serialises fetch, load/store and loader accesses onto
//                    the single memory port with alignment and timeout checks.
// Revision         : 1.0
//============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [1:0]        l_size,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    output logic              l_done,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_err,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_e        r_state;
    arb_owner_e        r_owner;
    logic              r_rr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_tmo;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [2:0]        w_grant;
    arb_owner_e        w_owner;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [1:0]        w_size;
    logic [DATA_W-1:0] w_wdata;
    logic              w_resp;

    mem_arb_pick u_pick (
        .i_f_req (f_req),
        .i_l_req (l_req),
        .i_d_req (d_req),
        .i_rr    (r_rr),
        .o_grant (w_grant),
        .o_owner (w_owner)
    );

    // Fetch is always a word read; it is the fallback when L and D are not granted.
    always_comb begin
        w_addr  = f_addr;
        w_we    = 1'b0;
        w_size  = SZ_W;
        w_wdata = '0;
        if (w_grant[2]) begin
            w_addr  = d_addr;
            w_we    = d_we;
            w_size  = d_size;
            w_wdata = d_wdata;
        end else if (w_grant[1]) begin
            w_addr  = l_addr;
            w_we    = l_we;
            w_size  = l_size;
            w_wdata = l_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= OWN_F;
            r_rr    <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_size  <= SZ_B;
            r_wdata <= '0;
            r_tmo   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_owner <= w_owner;
                        r_addr  <= w_addr;
                        r_we    <= w_we;
                        r_size  <= w_size;
                        r_wdata <= w_wdata;
                        // Point rr at the other F/L requester; D grants leave it alone.
                        if (!w_grant[2]) begin
                            r_rr <= w_grant[0];
                        end
                        if (misaligned(w_addr[2:0], w_size)) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= RESP;
                        end else begin
                            r_tmo   <= '0;
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        r_rdata <= r_we ? '0 : mem_rdata;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign mem_req   = (r_state == ACCESS);
    assign mem_we    = mem_req & r_we;
    assign mem_size  = r_size;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign w_resp  = (r_state == RESP);
    assign f_done  = w_resp && (r_owner == OWN_F);
    assign l_done  = w_resp && (r_owner == OWN_L);
    assign d_done  = w_resp && (r_owner == OWN_D);
    assign f_rdata = f_done ? r_rdata : '0;
    assign l_rdata = l_done ? r_rdata : '0;
    assign d_rdata = d_done ? r_rdata : '0;
    assign f_err   = f_done & r_err;
    assign l_err   = l_done & r_err;
    assign d_err   = d_done & r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
//============================================================================
// tb_mem_port_arbiter : directed and randomized transactions checked against
//                       a transaction-level model of arbitration and timing.
// Revision            : 1.0
//============================================================================
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req;                 // index 0 = F, 1 = L, 2 = D
    logic [63:0] addr  [3];
    logic [63:0] wdata [3];
    logic        we    [3];
    logic [1:0]  size  [3];
    logic        mem_ready;
    logic [63:0] mem_rdata;

    logic        f_done, l_done, d_done, f_err, l_err, d_err;
    logic [63:0] f_rdata, l_rdata, d_rdata;
    logic        mem_req, mem_we, busy;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr, mem_wdata;

    int n_chk = 0;
    int n_err = 0;
    bit m_rr  = 1'b0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (req[0]),
        .f_addr    (addr[0]),
        .l_req     (req[1]),
        .l_we      (we[1]),
        .l_size    (size[1]),
        .l_addr    (addr[1]),
        .l_wdata   (wdata[1]),
        .d_req     (req[2]),
        .d_we      (we[2]),
        .d_size    (size[2]),
        .d_addr    (addr[2]),
        .d_wdata   (wdata[2]),
        .f_done    (f_done),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .l_done    (l_done),
        .l_rdata   (l_rdata),
        .l_err     (l_err),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // D first; F/L contention resolved by whose turn it is; otherwise whoever asks.
    function automatic int pick_owner(input logic [2:0] r, input bit rr);
        if (r[2]) return 2;
        if (r[0] && r[1]) return rr ? 1 : 0;
        if (r[1]) return 1;
        return 0;
    endfunction

    // Starts between edges with the DUT idle and requests set up; returns
    // between edges in the idle cycle that follows the done pulse.
    task automatic run_txn(input int k, input logic [63:0] rd, input bit scramble, input bit hold);
        int          own, cyc, acc, e_acc, e_done;
        bit          got, mis, e_we, e_err;
        logic [1:0]  e_sz;
        logic [63:0] e_addr, e_wd, e_rdata;
        logic [2:0]  onehot;
        own    = pick_owner(req, m_rr);
        onehot = 3'(1 << own);
        if (own == 0) m_rr = 1'b1;
        else if (own == 1) m_rr = 1'b0;
        e_addr = addr[own];
        e_we   = (own == 0) ? 1'b0 : we[own];
        e_sz   = (own == 0) ? 2'b10 : size[own];
        e_wd   = (own == 0) ? 64'd0 : wdata[own];
        mis    = (e_addr % (64'd1 << e_sz)) != 64'd0;
        if (mis) begin
            e_acc = 0; e_done = 1; e_err = 1'b1; e_rdata = 64'd0;
        end else if (k < TIMEOUT) begin
            e_acc = k + 1; e_done = k + 2; e_err = 1'b0; e_rdata = e_we ? 64'd0 : rd;
        end else begin
            e_acc = TIMEOUT; e_done = TIMEOUT + 1; e_err = 1'b1; e_rdata = 64'd0;
        end
        acc = 0; cyc = 0; got = 1'b0;
        mem_ready = 1'($urandom_range(1, 0));
        mem_rdata = {$urandom, $urandom};
        while (!got && cyc < TIMEOUT + 6) begin
            @(posedge clk); #1;
            cyc++;
            if (scramble && cyc == 1) begin
                for (int i = 0; i < 3; i++) begin
                    addr[i]  = {$urandom, $urandom};
                    wdata[i] = {$urandom, $urandom};
                    we[i]    = 1'($urandom_range(1, 0));
                    size[i]  = 2'($urandom_range(3, 0));
                end
                if ($urandom_range(1, 0) == 1) req[own] = 1'b0;
            end
            chk("busy_active", 64'(busy), 64'd1);
            if (mem_req) begin
                if (acc == 0) begin
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_we", 64'(mem_we), 64'(e_we));
                    chk("mem_size", 64'(mem_size), 64'(e_sz));
                    chk("mem_wdata", mem_wdata, e_wd);
                end
                mem_ready = (acc == k);
                mem_rdata = rd;
                acc++;
            end else begin
                mem_ready = 1'($urandom_range(1, 0));
                mem_rdata = {$urandom, $urandom};
            end
            if (f_done || l_done || d_done) begin
                got = 1'b1;
                chk("done_owner", 64'({d_done, l_done, f_done}), 64'(onehot));
                chk("done_cycle", 64'(cyc), 64'(e_done));
                chk("f_rdata", f_rdata, (own == 0) ? e_rdata : 64'd0);
                chk("l_rdata", l_rdata, (own == 1) ? e_rdata : 64'd0);
                chk("d_rdata", d_rdata, (own == 2) ? e_rdata : 64'd0);
                chk("err", 64'({d_err, l_err, f_err}), e_err ? 64'(onehot) : 64'd0);
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("access_cycles", 64'(acc), 64'(e_acc));
        if (!hold) req[own] = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_after", 64'({d_done, l_done, f_done}), 64'd0);
    endtask

    initial begin
        req       = 3'b000;
        mem_ready = 1'b0;
        mem_rdata = 64'd0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 64'd0; wdata[i] = 64'd0; we[i] = 1'b0; size[i] = 2'b00;
        end

        // Reset state
        #2 reset = 1'b1;
        #1;
        chk("rst_ctl", 64'({busy, mem_req, mem_we, f_done, l_done, d_done, f_err, l_err, d_err}), 64'd0);
        chk("rst_mem", mem_addr | mem_wdata | 64'(mem_size), 64'd0);
        chk("rst_rdata", f_rdata | l_rdata | d_rdata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        m_rr = 1'b0;

        // Lone fetch, ready in the first access cycle
        addr[0] = 64'h40; req = 3'b001;
        run_txn(0, 64'h13, 1'b0, 1'b0);

        // Misaligned half, then an aligned word from L
        addr[1] = 64'h103; size[1] = 2'b01; we[1] = 1'b0; req = 3'b010;
        run_txn(0, 64'h55, 1'b0, 1'b0);
        addr[1] = 64'h104; size[1] = 2'b10; req = 3'b010;
        run_txn(2, 64'h1234_5678, 1'b0, 1'b0);

        // Three-way contention: D, then F, then L
        addr[0] = 64'h80;   addr[1] = 64'h20; size[1] = 2'b01; we[1] = 1'b0;
        addr[2] = 64'h1000; size[2] = 2'b11; we[2] = 1'b0;
        req = 3'b111;
        run_txn(1, 64'hAAAA_0001, 1'b0, 1'b0);
        run_txn(0, 64'hAAAA_0002, 1'b0, 1'b0);
        run_txn(0, 64'hAAAA_0003, 1'b0, 1'b0);

        // F and L held continuously; L writes a double word
        addr[0] = 64'h200; addr[1] = 64'h100; size[1] = 2'b11; we[1] = 1'b1; wdata[1] = 64'hDEAD;
        req = 3'b011;
        for (int t = 0; t < 4; t++) run_txn(0, 64'hBEEF_0000 + 64'(t), 1'b0, 1'b1);
        req = 3'b000;

        // Timeout on an L read that never sees mem_ready
        addr[1] = 64'h108; size[1] = 2'b11; we[1] = 1'b0; req = 3'b010;
        run_txn(TIMEOUT + 4, 64'hFFFF_FFFF, 1'b0, 1'b0);

        // Reset in the second access cycle, then a pending fetch served normally
        addr[0] = 64'h300; req = 3'b001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("rst_mid_done", 64'({d_done, l_done, f_done}), 64'd0);
        @(negedge clk) reset = 1'b0;
        m_rr = 1'b0;
        run_txn(1, 64'hC0DE, 1'b0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            if (req == 3'b000) req = 3'($urandom_range(7, 1));
            else req = req | 3'($urandom_range(7, 0) & $urandom_range(7, 0));
            for (int i = 0; i < 3; i++) begin
                addr[i]  = {$urandom, $urandom};
                if ($urandom_range(9, 0) < 7) addr[i][2:0] = 3'b000;
                wdata[i] = {$urandom, $urandom};
                we[i]    = 1'($urandom_range(1, 0));
                size[i]  = 2'($urandom_range(3, 0));
            end
            run_txn(($urandom_range(7, 0) == 0) ? TIMEOUT + 1 : int'($urandom_range(4, 0)),
                    {$urandom, $urandom}, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle 64-bit core between three requesters: instruction fetch (F), load/store (L) and the debug/program loader (D).
- Sits between the multicycle control FSM / datapath and the memory.
- Serialises one access at a time, checks alignment, bounds each access with a timeout, and returns data or an error to the owning requester with a one-cycle done pulse.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- TIMEOUT, 16, maximum ACCESS cycles waiting for mem_ready (legal range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- f_req  input  1  fetch request; level, held until f_done.
- f_addr  input  ADDR_W  fetch address; read only, size fixed to word (2'b10).
- l_req, d_req  input  1  load/store and loader requests; level, held until done.
- l_we, d_we  input  1  1 = write, 0 = read.
- l_size, d_size  input  2  access size: 00 byte, 01 half, 10 word, 11 double (same encoding as the control unit's MemSize).
- l_addr, d_addr  input  ADDR_W  access address.
- l_wdata, d_wdata  input  DATA_W  write data.
- f_done, l_done, d_done  output  1  one-cycle completion pulse to the owner.
- f_rdata, l_rdata, d_rdata  output  DATA_W  read data; valid only while the matching done is high, 0 otherwise.
- f_err, l_err, d_err  output  1  error flag; qualified by done.
- mem_req  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_size  output  2  memory access size.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ready  input  1  memory completion; read data valid this cycle.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Interface rule: one clock (clk); reset is asynchronous, active-high.
- Reset values: state = IDLE, rr = 0, all outputs 0. Asserting reset mid-access drops mem_req immediately, emits no done pulse and discards the access.
- All outputs are registered or decoded from registered state; no combinational path from any *_req to mem_*.
- States:
  - IDLE. If any req is high, the picker selects a winner, and owner, addr, we, size and wdata are latched.
    - Misaligned (addr mod 2^size != 0) → RESP with err = 1 and no memory access.
    - Aligned → ACCESS with tmo = 0.
    - No req → stay in IDLE.
  - ACCESS. mem_req = 1 and mem_* are driven from the latches.
    - mem_ready = 1 → capture mem_rdata (0 for writes), err = 0, go to RESP.
    - Else, if tmo == TIMEOUT-1 → err = 1, rdata = 0, go to RESP.
    - Else → tmo + 1.
  - RESP. The owner's done = 1 for exactly one cycle, with its rdata and err. Next state is always IDLE.
- Priority: D beats everything. Between F and L the picker is round-robin: rr = 0 favours F, rr = 1 favours L, and rr flips to the opposite requester after each granted F/L access. A lone requester always wins.
- Latency: minimum 3 cycles from req sampled in IDLE to done (IDLE, ACCESS with ready, RESP). Back-to-back accesses from the same requester take 3 cycles each.
- Requester rule: drop req, or present a new access, in the cycle after done. A req still high in IDLE is treated as a new access.
- A req deasserted mid-access does not abort it; the access completes and done still pulses.
- Attribute changes on addr/we/etc. after the IDLE latch are ignored.
- mem_ready outside ACCESS is ignored.
- tmo is 8 bits wide and cleared on entry to ACCESS.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - owner enum {OWN_F, OWN_L, OWN_D};
  - size constants SZ_B/SZ_H/SZ_W/SZ_D;
  - a misalignment function of (addr[2:0], size).
- One sub-module, mem_arb_pick: combinational winner select from (f_req, l_req, d_req, rr), producing a one-hot grant and owner.

Test Plan:
- F only, addr 0x40, mem_ready in first ACCESS cycle, mem_rdata 0x00000013 → f_done at cycle 2, f_rdata 0x13, f_err 0; mem_size 10; busy high for cycles 1-2.
- F and L both request continuously, L writes 0xDEAD at 0x100, size 11 → grants alternate F, L, F, L; each done 3 cycles apart; mem_wdata 0xDEAD and mem_we = 1 on L accesses.
- D, L and F requested in the same cycle → D served first; then F (rr = 0) and then L.
- L reads half at 0x103 → no mem_req, l_done with l_err = 1 at cycle 1 (RESP); word at 0x104 accepted.
- L read with mem_ready held 0, TIMEOUT = 16 → mem_req high exactly 16 cycles, then l_done with l_err = 1 and l_rdata 0.
- Reset asserted in the 2nd ACCESS cycle → mem_req and busy drop asynchronously, no done pulse; after release, a pending F req is served normally.
